pwm_multi_fade: RTL and testbench

- Multi-channel PWM generator for LED dimming on the arm controller.
- Successor to the single-channel fixed-period PWM: adds a runtime-programmable period, a parametrised channel count and resolution, and per-channel hardware fading towards a written target duty.
- Duty changes take effect only at period boundaries, so the outputs never glitch.
- Sits between the control register interface and the LED drivers.

---
 rtl/pwm_pkg.sv | 53 +++++
 rtl/pwm_fade_ch.sv | 79 +++++++
 rtl/pwm_multi_fade.sv | 97 +++++++++
 tb/tb_pwm_multi_fade.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and fade arithmetic for the multi-channel PWM
// Purpose: default duty width, ramp-direction encoding and the saturating
//          fade-step function used by every channel.
// Ports:   none (package)
package pwm_pkg;

   localparam int PWM_WIDTH = 8;

   // Fade arithmetic runs at a fixed 32-bit width so one function serves any
   // channel WIDTH up to 31 bits; callers zero-extend and slice the result.
   localparam int SAT_W = 32;

   typedef enum logic [1:0] {
      RAMP_HOLD,
      RAMP_UP,
      RAMP_DOWN
   } ramp_dir_e;

   // Moves cur towards tgt by min(step, |tgt-cur|). The distance is taken one
   // bit wider than the operands, so a large step can neither overshoot the
   // target nor wrap around zero or full scale.
   function automatic logic [SAT_W-1:0] sat_step(
      input logic [SAT_W-1:0] cur,
      input logic [SAT_W-1:0] tgt,
      input logic [SAT_W-1:0] step
   );
      ramp_dir_e        dir;
      logic [SAT_W:0]   diff;
      logic [SAT_W-1:0] nxt;
      diff = '0;
      nxt  = cur;
      if (tgt > cur) begin
         dir = RAMP_UP;
      end else if (tgt < cur) begin
         dir = RAMP_DOWN;
      end else begin
         dir = RAMP_HOLD;
      end
      case (dir)
         RAMP_UP: begin
            diff = {1'b0, tgt} - {1'b0, cur};
            nxt  = ({1'b0, step} >= diff) ? tgt : cur + step;
         end
         RAMP_DOWN: begin
            diff = {1'b0, cur} - {1'b0, tgt};
            nxt  = ({1'b0, step} >= diff) ? tgt : cur - step;
         end
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/pwm_fade_ch.sv
// rtl/pwm_fade_ch.sv - one PWM channel: target/current duty, fading and output compare
// Purpose: holds the written target, the live duty and the immediate flag;
//          updates the live duty only at period wraps.
// Ports:   clk, rst_n      clock, async active-low reset
//          wr_sel          write strobe already decoded for this channel
//          wr_duty, wr_imm target duty and jump-vs-fade select of the write
//          wrap, tick      period wrap and ramp tick from the shared timebase
//          step            fade increment per ramp tick (0 freezes)
//          counter         shared period counter
//          pwm_out         registered PWM output
//          busy            live duty differs from target
module pwm_fade_ch
   import pwm_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_sel,
   input  logic [WIDTH-1:0] wr_duty,
   input  logic             wr_imm,
   input  logic             wrap,
   input  logic             tick,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] counter,
   output logic             pwm_out,
   output logic             busy
);

   logic [WIDTH-1:0] target_q, target_d;
   logic [WIDTH-1:0] current_q, current_d;
   logic             imm_q, imm_d;
   logic             pwm_q, pwm_d;
   logic [SAT_W-1:0] ramp_ext;
   logic             unused_ramp_hi;

   assign ramp_ext       = sat_step(SAT_W'(current_q), SAT_W'(target_q), SAT_W'(step));
   // The step result never exceeds max(current, target), so these bits are zero.
   assign unused_ramp_hi = |ramp_ext[SAT_W-1:WIDTH];

   always_comb begin
      target_d  = target_q;
      current_d = current_q;
      imm_d     = imm_q;
      pwm_d     = (counter < current_q);
      // The wrap acts on the registered target/imm, so a write landing in the
      // wrap cycle is only stored here and takes effect at the following wrap.
      if (wrap) begin
         if (imm_q) begin
            current_d = target_q;
            imm_d     = 1'b0;
         end else if (tick) begin
            current_d = ramp_ext[WIDTH-1:0];
         end
      end
      if (wr_sel) begin
         target_d = wr_duty;
         imm_d    = wr_imm;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_q  <= '0;
         current_q <= '0;
         imm_q     <= 1'b0;
         pwm_q     <= 1'b0;
      end else begin
         target_q  <= target_d;
         current_q <= current_d;
         imm_q     <= imm_d;
         pwm_q     <= pwm_d;
      end
   end

   assign pwm_out = pwm_q;
   assign busy    = (current_q != target_q);

endmodule

// File: rtl/pwm_multi_fade.sv
// rtl/pwm_multi_fade.sv - multi-channel PWM with programmable period and hardware fading
// Purpose: shared period counter, period register, ramp prescaler and write
//          decode feeding N_CH fading channels.
// Ports:   clk, reset_n    clock, async active-low reset
//          period          counter terminal value, sampled at each wrap
//          wr_en, wr_ch    one-cycle target write strobe and channel index
//          wr_duty, wr_imm target duty, 1 = jump at next wrap, 0 = fade
//          step            fade increment per ramp tick
//          pwm_out         registered PWM outputs
//          period_end      one-cycle pulse aligned with the last count's output
//          busy            per-channel fade/jump pending
module pwm_multi_fade
   import pwm_pkg::*;
#(
   parameter int  N_CH     = 4,
   parameter int  WIDTH    = PWM_WIDTH,
   parameter int  RAMP_DIV = 4,
   parameter int  PRESC_W  = 8,
   localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] period,
   input  logic             wr_en,
   input  logic [CH_W-1:0]  wr_ch,
   input  logic [WIDTH-1:0] wr_duty,
   input  logic             wr_imm,
   input  logic [WIDTH-1:0] step,
   output logic [N_CH-1:0]  pwm_out,
   output logic             period_end,
   output logic [N_CH-1:0]  busy
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RAMP_DIV - 1);

   logic [WIDTH-1:0]   counter_q, counter_d;
   logic [WIDTH-1:0]   period_q, period_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               period_end_q, period_end_d;
   logic               wrap;
   logic               tick;

   // period_q is 0 out of reset, so the first cycle after release is itself a
   // wrap: that is where the programmed period is first loaded.
   always_comb begin
      wrap         = (counter_q == period_q);
      tick         = wrap && (presc_q == PRESC_LAST);
      counter_d    = counter_q + 1'b1;
      period_d     = period_q;
      presc_d      = presc_q;
      period_end_d = wrap;
      if (wrap) begin
         counter_d = '0;
         period_d  = period;
         presc_d   = tick ? '0 : presc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counter_q    <= '0;
         period_q     <= '0;
         presc_q      <= '0;
         period_end_q <= 1'b0;
      end else begin
         counter_q    <= counter_d;
         period_q     <= period_d;
         presc_q      <= presc_d;
         period_end_q <= period_end_d;
      end
   end

   assign period_end = period_end_q;

   // Indices at or above N_CH match no channel, so such writes are dropped.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic wr_sel;
      assign wr_sel = wr_en && (32'(wr_ch) == i);

      pwm_fade_ch #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk     (clk),
         .rst_n   (reset_n),
         .wr_sel  (wr_sel),
         .wr_duty (wr_duty),
         .wr_imm  (wr_imm),
         .wrap    (wrap),
         .tick    (tick),
         .step    (step),
         .counter (counter_q),
         .pwm_out (pwm_out[i]),
         .busy    (busy[i])
      );
   end

endmodule

// File: tb/tb_pwm_multi_fade.sv
// tb/tb_pwm_multi_fade.sv - self-checking bench for pwm_multi_fade
module tb_pwm_multi_fade;

   localparam int N_CH     = 4;
   localparam int WIDTH    = 8;
   localparam int RAMP_DIV = 4;
   localparam int PRESC_W  = 8;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [WIDTH-1:0] period = '0;
   logic             wr_en = 1'b0;
   logic [1:0]       wr_ch = '0;
   logic [WIDTH-1:0] wr_duty = '0;
   logic             wr_imm = 1'b0;
   logic [WIDTH-1:0] step = '0;
   logic [N_CH-1:0]  pwm_out;
   logic             period_end;
   logic [N_CH-1:0]  busy;

   pwm_multi_fade #(
      .N_CH     (N_CH),
      .WIDTH    (WIDTH),
      .RAMP_DIV (RAMP_DIV),
      .PRESC_W  (PRESC_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .period     (period),
      .wr_en      (wr_en),
      .wr_ch      (wr_ch),
      .wr_duty    (wr_duty),
      .wr_imm     (wr_imm),
      .step       (step),
      .pwm_out    (pwm_out),
      .period_end (period_end),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Reference model: counter position, period, wraps since last tick, and
   // per-channel duties as plain integers.
   int m_cnt, m_per, m_presc;
   int m_tgt [N_CH];
   int m_cur [N_CH];
   bit m_imm [N_CH];

   task automatic model_reset();
      m_cnt = 0; m_per = 0; m_presc = 0;
      for (int i = 0; i < N_CH; i++) begin
         m_tgt[i] = 0; m_cur[i] = 0; m_imm[i] = 0;
      end
   endtask

   task automatic do_cycle();
      logic [N_CH-1:0] e_pwm, e_busy;
      bit e_pe, is_tick;
      int d, mv;
      e_pe = (m_cnt == m_per);
      for (int i = 0; i < N_CH; i++) e_pwm[i] = (m_cnt < m_cur[i]);
      if (e_pe) begin
         is_tick = ((m_presc + 1) % RAMP_DIV) == 0;
         for (int i = 0; i < N_CH; i++) begin
            if (m_imm[i]) begin
               m_cur[i] = m_tgt[i];
               m_imm[i] = 0;
            end else if (is_tick) begin
               d  = m_tgt[i] - m_cur[i];
               mv = (d < 0) ? -d : d;
               if (int'(step) < mv) mv = int'(step);
               m_cur[i] = m_cur[i] + ((d < 0) ? -mv : mv);
            end
         end
         m_presc = is_tick ? 0 : m_presc + 1;
         m_per   = int'(period);
         m_cnt   = 0;
      end else begin
         m_cnt++;
      end
      if (wr_en && int'(wr_ch) < N_CH) begin
         m_tgt[wr_ch] = int'(wr_duty);
         m_imm[wr_ch] = wr_imm;
      end
      for (int i = 0; i < N_CH; i++) e_busy[i] = (m_cur[i] != m_tgt[i]);
      @(posedge clk);
      #1;
      chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
      chk("period_end", 32'(period_end), 32'(e_pe));
      chk("busy", 32'(busy), 32'(e_busy));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) do_cycle();
   endtask

   task automatic write_ch(input int ch, input int duty, input bit imm);
      wr_en = 1'b1; wr_ch = 2'(ch); wr_duty = 8'(duty); wr_imm = imm;
      do_cycle();
      wr_en = 1'b0;
   endtask

   task automatic run_count(input int n, input int ch, output int hi, output int pe);
      hi = 0; pe = 0;
      for (int k = 0; k < n; k++) begin
         do_cycle();
         hi += int'(pwm_out[ch]);
         pe += int'(period_end);
      end
   endtask

   task automatic gap(output int n);
      n = 0;
      do begin
         do_cycle();
         n++;
      end while (!period_end && n < 400);
   endtask

   task automatic wait_idle(input int ch, input int limit);
      int k;
      k = 0;
      while (busy[ch] && k < limit) begin
         do_cycle();
         k++;
      end
   endtask

   int hi, pe, n;

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pwm", 32'(pwm_out), 0);
      chk("rst_period_end", 32'(period_end), 0);
      chk("rst_busy", 32'(busy), 0);

      // Static duty with immediate jump
      period = 8'd9;
      @(negedge clk) reset_n = 1'b1;
      write_ch(0, 3, 1);
      run(30);
      run_count(10, 0, hi, pe);
      chk("static_duty_ch0", hi, 3);
      chk("static_period_end", pe, 1);
      run_count(20, 1, hi, pe);
      chk("static_ch1_low", hi, 0);
      chk("static_period_end_20", pe, 2);

      // Fade up in steps of 5 to 17
      period = 8'd19;
      step   = 8'd5;
      run(25);
      write_ch(1, 17, 0);
      wait_idle(1, 1000);
      chk("fade_up_done", 32'(busy[1]), 0);
      run_count(20, 1, hi, pe);
      chk("fade_up_duty", hi, 17);

      // Fade down from 200 with a full-scale step
      write_ch(1, 200, 1);
      run(40);
      run_count(20, 1, hi, pe);
      chk("duty_200_high", hi, 20);
      step = 8'd255;
      write_ch(1, 0, 0);
      wait_idle(1, 1000);
      chk("fade_down_done", 32'(busy[1]), 0);
      run_count(40, 1, hi, pe);
      chk("fade_down_low", hi, 0);

      // period = 0: every cycle is a wrap
      step   = 8'd0;
      period = 8'd0;
      write_ch(3, 1, 1);
      run(30);
      run_count(10, 3, hi, pe);
      chk("p0_high", hi, 10);
      chk("p0_period_end", pe, 10);

      // Full duty at period 254
      period = 8'd254;
      write_ch(0, 255, 1);
      run(300);
      run_count(255, 0, hi, pe);
      chk("duty255_high", hi, 255);
      chk("duty255_period_end", pe, 1);

      // Period change mid-period: old period completes first
      period = 8'd9;
      run(300);
      gap(n);
      run(3);
      period = 8'd4;
      gap(n);
      chk("old_period_gap", n + 3, 10);
      gap(n);
      chk("new_period_gap", n, 5);

      // Write collides with the wrap for the same channel
      period = 8'd99;
      run(120);
      write_ch(2, 50, 1);
      run(110);
      n = 0;
      while (m_cnt != m_per && n < 300) begin
         do_cycle();
         n++;
      end
      write_ch(2, 80, 1);
      run_count(100, 2, hi, pe);
      chk("collide_old_duty", hi, 50);
      run_count(100, 2, hi, pe);
      chk("collide_new_duty", hi, 80);

      // Asynchronous reset in the middle of a fade
      period = 8'd9;
      step   = 8'd1;
      run(110);
      write_ch(0, 5, 1);
      run(20);
      write_ch(0, 9, 0);
      n = 0;
      while (!pwm_out[0] && n < 20) begin
         do_cycle();
         n++;
      end
      chk("pre_reset_pwm0", 32'(pwm_out[0]), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_pwm", 32'(pwm_out), 0);
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_period_end", 32'(period_end), 0);
      model_reset();
      @(negedge clk) reset_n = 1'b1;
      run(30);
      chk("post_rst_pwm", 32'(pwm_out), 0);

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_ch   = 2'($urandom_range(0, N_CH - 1));
         wr_duty = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
         wr_imm  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 99) == 0) period = 8'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) step = 8'($urandom_range(0, 6));
         do_cycle();
      end
      wr_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
